// File: rtl/pwm_pkg.sv
// ============================================================================
// Module : pwm_pkg
// Brief  : Shared PWM constants and helpers for the generator/decoder pair.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

  localparam int PWM_WIDTH_DEF = 8;
  localparam int SYNC_DEF      = 2;

  // PWM period in clk cycles for a given level width
  function automatic int pwm_period(input int width);
    return 1 << width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_ff.sv
// ============================================================================
// Module : sync_ff
// Brief  : Generic multi-stage bit synchroniser, async active-low clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/pwm_decoder.sv
// ============================================================================
// Module : pwm_decoder
// Brief  : Measures PWM duty over a 2**WIDTH-cycle window and recovers level.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_decoder
  import pwm_pkg::*;
#(
  parameter int WIDTH  = PWM_WIDTH_DEF,
  parameter bit INVERT = 1'b0,
  parameter int SYNC   = SYNC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] level,
  output logic             level_valid,
  output logic             sat,
  output logic             idle,
  output logic             changed
);

  localparam int             PERIOD = pwm_period(WIDTH);
  localparam logic [WIDTH:0] FULL   = PERIOD[WIDTH:0];

  logic             s;
  logic             s_dly_q;
  logic             act;
  logic             edge_det;
  logic             term;
  logic [WIDTH:0]   total;
  logic [WIDTH-1:0] new_level;

  logic [WIDTH-1:0] win_cnt_q,   win_cnt_d;
  logic [WIDTH:0]   act_cnt_q,   act_cnt_d;
  logic             edge_seen_q, edge_seen_d;
  logic [WIDTH-1:0] level_q,     level_d;
  logic             valid_q,     valid_d;
  logic             sat_q,       sat_d;
  logic             idle_q,      idle_d;
  logic             changed_q,   changed_d;

  sync_ff #(
    .STAGES (SYNC)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pwm_in),
    .q_o   (s)
  );

  assign act       = s ^ INVERT;
  assign edge_det  = s ^ s_dly_q;
  assign term      = &win_cnt_q;
  assign total     = act_cnt_q + {{WIDTH{1'b0}}, act};
  // A fully active window overflows the level range, so clamp it
  assign new_level = (total == FULL) ? {WIDTH{1'b1}} : total[WIDTH-1:0];

  always_comb begin
    win_cnt_d   = win_cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    act_cnt_d   = total;
    edge_seen_d = edge_seen_q | edge_det;
    level_d     = level_q;
    valid_d     = 1'b0;
    sat_d       = sat_q;
    idle_d      = idle_q;
    changed_d   = 1'b0;
    if (term) begin
      // Terminal-cycle sample and edge belong to the window being closed
      act_cnt_d   = '0;
      edge_seen_d = 1'b0;
      level_d     = new_level;
      valid_d     = 1'b1;
      sat_d       = (total == FULL);
      idle_d      = ~(edge_seen_q | edge_det);
      changed_d   = (new_level != level_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_dly_q     <= 1'b0;
      win_cnt_q   <= '0;
      act_cnt_q   <= '0;
      edge_seen_q <= 1'b0;
      level_q     <= '0;
      valid_q     <= 1'b0;
      sat_q       <= 1'b0;
      idle_q      <= 1'b1;
      changed_q   <= 1'b0;
    end else begin
      s_dly_q     <= s;
      win_cnt_q   <= win_cnt_d;
      act_cnt_q   <= act_cnt_d;
      edge_seen_q <= edge_seen_d;
      level_q     <= level_d;
      valid_q     <= valid_d;
      sat_q       <= sat_d;
      idle_q      <= idle_d;
      changed_q   <= changed_d;
    end
  end

  assign level       = level_q;
  assign level_valid = valid_q;
  assign sat         = sat_q;
  assign idle        = idle_q;
  assign changed     = changed_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_decoder.sv
// ============================================================================
// Module : tb_pwm_decoder
// Brief  : Directed bench for pwm_decoder driven by a behavioural PWM generator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pwm_decoder;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic       gen_en = 1'b1;
  logic [7:0] gen_lvl = 8'h40;
  logic [1:0] mode   = 2'd0;
  logic [7:0] gen_cnt;
  logic       gen_rst_n;
  logic       gen_out;
  logic       inv_out;
  logic       pwm_in;

  logic [7:0] level;
  logic       level_valid, sat, idle, changed;
  logic [7:0] inv_level;
  logic       inv_valid, inv_sat, inv_idle, inv_changed;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int n;

  always #5 clk = ~clk;

  // Reference generator: high while counter < level, period 256
  assign gen_rst_n = rst_n & gen_en;
  always_ff @(posedge clk or negedge gen_rst_n) begin
    if (!gen_rst_n) gen_cnt <= 8'd0;
    else            gen_cnt <= gen_cnt + 8'd1;
  end
  assign gen_out = gen_rst_n & (gen_cnt < gen_lvl);
  assign inv_out = ~(gen_rst_n & (gen_cnt < 8'h25));
  assign pwm_in  = (mode == 2'd0) ? gen_out : (mode == 2'd2);

  pwm_decoder #(.WIDTH(8), .INVERT(1'b0), .SYNC(2)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_in      (pwm_in),
    .level       (level),
    .level_valid (level_valid),
    .sat         (sat),
    .idle        (idle),
    .changed     (changed)
  );

  pwm_decoder #(.WIDTH(8), .INVERT(1'b1), .SYNC(2)) u_dut_inv (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_in      (inv_out),
    .level       (inv_level),
    .level_valid (inv_valid),
    .sat         (inv_sat),
    .idle        (inv_idle),
    .changed     (inv_changed)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!level_valid && cycles < 600);
    chk("valid_seen", 32'(level_valid), 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_level"},   32'(level),       32'h00);
    chk({tag, "_valid"},   32'(level_valid), 32'd0);
    chk({tag, "_sat"},     32'(sat),         32'd0);
    chk({tag, "_idle"},    32'(idle),        32'd1);
    chk({tag, "_changed"}, 32'(changed),     32'd0);
  endtask

  initial begin
    int offs[6] = '{0, 1, 37, 128, 200, 255};

    // Async reset before any clock edge
    #2 rst_n = 1'b0;
    #1 chk_reset("rst0");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Steady level 0x40, pulses every 256 cycles
    wait_valid(n);
    chk("first_lat", 32'(n), 32'd256);
    for (int i = 0; i < 3; i++) begin
      wait_valid(n);
      chk("t1_period",  32'(n),       32'd256);
      chk("t1_level",   32'(level),   32'h40);
      chk("t1_sat",     32'(sat),     32'd0);
      chk("t1_idle",    32'(idle),    32'd0);
      chk("t1_changed", 32'(changed), 32'd0);
    end

    // Inverted decoder against inverted generator at 0x25
    chk("t4_valid", 32'(inv_valid), 32'd1);
    chk("t4_level", 32'(inv_level), 32'h25);
    chk("t4_sat",   32'(inv_sat),   32'd0);
    chk("t4_idle",  32'(inv_idle),  32'd0);

    // Level changes mid-window: 0x40 -> 0x10 -> 0xC0
    repeat (100) @(negedge clk);
    gen_lvl = 8'h10;
    wait_valid(n);
    wait_valid(n);
    chk("t3_lvl10", 32'(level), 32'h10);
    repeat (100) @(negedge clk);
    gen_lvl = 8'hC0;
    wait_valid(n);
    chk("t3_trans",     32'(level),   32'h6C);
    chk("t3_trans_chg", 32'(changed), 32'd1);
    wait_valid(n);
    chk("t3_lvlC0", 32'(level),   32'hC0);
    chk("t3_chg1",  32'(changed), 32'd1);
    wait_valid(n);
    chk("t3_hold",  32'(level),   32'hC0);
    chk("t3_chg0",  32'(changed), 32'd0);

    // Line stuck low, then stuck high
    mode = 2'd1;
    wait_valid(n);
    wait_valid(n);
    chk("t2_lo_level", 32'(level), 32'h00);
    chk("t2_lo_idle",  32'(idle),  32'd1);
    chk("t2_lo_sat",   32'(sat),   32'd0);
    mode = 2'd2;
    wait_valid(n);
    wait_valid(n);
    chk("t2_hi_level", 32'(level), 32'hFF);
    chk("t2_hi_sat",   32'(sat),   32'd1);
    chk("t2_hi_idle",  32'(idle),  32'd1);
    mode = 2'd0;

    // 0xFF at various generator phase offsets
    gen_lvl = 8'hFF;
    foreach (offs[k]) begin
      @(negedge clk);
      rst_n  = 1'b0;
      gen_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (offs[k]) @(negedge clk);
      gen_en = 1'b1;
      repeat (3) wait_valid(n);
      chk($sformatf("t5_level_off%0d", offs[k]), 32'(level), 32'hFF);
      chk($sformatf("t5_sat_off%0d", offs[k]),   32'(sat),   32'd0);
      chk($sformatf("t5_idle_off%0d", offs[k]),  32'(idle),  32'd0);
    end

    // Reset pulse at win_cnt = 0x80
    gen_lvl = 8'h40;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(n);
    wait_valid(n);
    chk("t6_pre_level", 32'(level), 32'h40);
    repeat (128) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("t6_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_valid(n);
    chk("t6_lat", 32'(n), 32'd256);
    wait_valid(n);
    chk("t6_level", 32'(level), 32'h40);
    chk("t6_sat",   32'(sat),   32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

`default_nettype wire
